// File: rtl/ahb_out_arb_rr4_qos.sv
// Round-robin output-stage arbiter for one shared AHB slave port (4 input ports).
// Optional fixed-port precedence with anti-starvation is enabled by ARB_PRIO_EN.
module ahb_out_arb_rr4_qos #(
  parameter int unsigned INCR_MAX_BEATS = 8,
  parameter int unsigned PRIO_PORT      = 0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [3:0] req_port,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [1:0] addr_in_port,
  output logic       no_port,
  output logic       arb_hold
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [2:0] BU_WRAP4  = 3'd2;
  localparam logic [2:0] BU_INCR4  = 3'd3;
  localparam logic [2:0] BU_WRAP8  = 3'd4;
  localparam logic [2:0] BU_INCR8  = 3'd5;
  localparam logic [2:0] BU_WRAP16 = 3'd6;
  localparam logic [2:0] BU_INCR16 = 3'd7;

  localparam logic [3:0] INCR_LIMIT = 4'(INCR_MAX_BEATS);
  localparam logic [3:0] INCR_LOAD  = 4'(INCR_MAX_BEATS - 2);

  if (INCR_MAX_BEATS < 2 || INCR_MAX_BEATS > 15) begin : g_bad_incr_max
    $error("ahb_out_arb_rr4_qos: INCR_MAX_BEATS must be in 2..15");
  end
  if (PRIO_PORT > 3) begin : g_bad_prio_port
    $error("ahb_out_arb_rr4_qos: PRIO_PORT must be in 0..3");
  end

  typedef enum logic [1:0] {NOPORT, OWNED, HELD} state_t;

  state_t     state_q, state_n;
  logic [1:0] cur_q, cur_n;
  logic [3:0] remain_q, remain_n;
  logic [3:0] incr_q, incr_n;
  logic       hold_q, hold_raw, hold_n;
  logic [1:0] low_idx, rr_idx, scan_idx, pick_idx;
  logic       rr_found, pick;

  // Burst tracking from the current address phase
  always_comb begin
    remain_n = remain_q;
    hold_raw = hold_q;
    incr_n   = incr_q;
    if (!HSELM || HTRANSM == TR_IDLE) begin
      remain_n = '0;
      hold_raw = 1'b0;
      incr_n   = '0;
    end else begin
      case (HTRANSM)
        TR_NONSEQ: begin
          case (HBURSTM)
            BU_WRAP4, BU_INCR4:   begin remain_n = 4'd2;  hold_raw = 1'b1; incr_n = '0; end
            BU_WRAP8, BU_INCR8:   begin remain_n = 4'd6;  hold_raw = 1'b1; incr_n = '0; end
            BU_WRAP16, BU_INCR16: begin remain_n = 4'd14; hold_raw = 1'b1; incr_n = '0; end
            BU_INCR: begin
              remain_n = INCR_LOAD;
              hold_raw = 1'b1;
              // chained INCRs keep counting inside the same window
              if (!hold_q || incr_q == '0) incr_n = 4'd1;
            end
            default: begin remain_n = '0; hold_raw = 1'b0; incr_n = '0; end
          endcase
        end
        TR_SEQ: begin
          if (remain_q == '0) hold_raw = 1'b0;
          else                remain_n = remain_q - 4'd1;
          if (incr_q != '0 && incr_q != 4'd15) incr_n = incr_q + 4'd1;
        end
        default: ;
      endcase
    end
    hold_n = hold_raw && !(incr_n >= INCR_LIMIT);
  end

  always_comb begin
    low_idx  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (req_port[3-i]) low_idx = 2'(3 - i);
    end
    for (int unsigned i = 1; i < 4; i++) begin
      scan_idx = cur_q + 2'(i);
      if (!rr_found && req_port[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

`ifdef ARB_PRIO_EN
  localparam logic [1:0] PRIO_IDX = 2'(PRIO_PORT);
  logic [1:0] win_q, win_n;
  logic       prio_req, others_req;
  assign prio_req   = req_port[PRIO_IDX];
  assign others_req = |(req_port & ~(4'b0001 << PRIO_IDX));
`endif

  always_comb begin
    state_n  = state_q;
    cur_n    = cur_q;
    pick     = 1'b0;
    pick_idx = low_idx;
`ifdef ARB_PRIO_EN
    win_n    = win_q;
`endif
    if (state_q == HELD) begin
      if (!hold_n && !HMASTLOCKM) state_n = OWNED;
    end else if (state_q == OWNED && (hold_n || HMASTLOCKM)) begin
      state_n = HELD;
    end else begin
      if (state_q == OWNED) begin
        pick     = rr_found;
        pick_idx = rr_idx;
      end else begin
        pick     = |req_port;
        pick_idx = low_idx;
      end
`ifdef ARB_PRIO_EN
      if (prio_req && win_q != 2'd2) begin
        pick     = 1'b1;
        pick_idx = PRIO_IDX;
      end
      if (pick) begin
        if (pick_idx == PRIO_IDX && others_req) win_n = (win_q == 2'd2) ? 2'd1 : win_q + 2'd1;
        else                                    win_n = '0;
      end
`endif
      if (pick) begin
        state_n = OWNED;
        cur_n   = pick_idx;
      end else if (!HSELM) begin
        state_n = NOPORT;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= NOPORT;
      cur_q    <= '0;
      remain_q <= '0;
      incr_q   <= '0;
      hold_q   <= 1'b0;
`ifdef ARB_PRIO_EN
      win_q    <= '0;
`endif
    end else if (HREADYM) begin
      state_q  <= state_n;
      cur_q    <= cur_n;
      remain_q <= remain_n;
      incr_q   <= incr_n;
      hold_q   <= hold_n;
`ifdef ARB_PRIO_EN
      win_q    <= win_n;
`endif
    end
  end

  assign addr_in_port = cur_q;
  assign no_port      = (state_q == NOPORT);
  assign arb_hold     = (state_q == HELD);

endmodule

// File: tb/tb_ahb_out_arb_rr4_qos.sv
// Directed self-checking bench for ahb_out_arb_rr4_qos (INCR_MAX_BEATS=8, PRIO_PORT=3).
module tb_ahb_out_arb_rr4_qos;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic       arb_hold;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, WRAP16 = 3'd6, INCR8 = 3'd5, INCR16 = 3'd7;

  ahb_out_arb_rr4_qos #(.INCR_MAX_BEATS(8), .PRIO_PORT(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_in_port), .no_port(no_port), .arb_hold(arb_hold)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; req_port = '0; HREADYM = 1'b1; HSELM = 1'b0;
    HTRANSM = IDLE; HBURSTM = SINGLE; HMASTLOCKM = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; req_port = '0; HREADYM = 1'b1; HSELM = 1'b0;
    HTRANSM = IDLE; HBURSTM = SINGLE; HMASTLOCKM = 1'b0;
    #1;
    checks++; if (no_port !== 1'b1) begin errors++; $display("FAIL reset_no_port: got %b expected 1", no_port); end
    checks++; if (addr_in_port !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr_in_port); end
    checks++; if (arb_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", arb_hold); end
    HRESETn = 1'b1;
  endtask

  task automatic test_basic_grant();
    do_reset();
    req_port = 4'b0110;
    step();
    checks++; if (addr_in_port !== 2'd1 || no_port !== 1'b0) begin errors++; $display("FAIL first_grant: got port %0d no_port %b expected port 1 no_port 0", addr_in_port, no_port); end
    step();
    checks++; if (addr_in_port !== 2'd2) begin errors++; $display("FAIL rotate_to_2: got %0d expected 2", addr_in_port); end
    req_port = 4'b0000;
    step();
    checks++; if (no_port !== 1'b1) begin errors++; $display("FAIL release_noport: got %b expected 1", no_port); end
  endtask

  task automatic test_keep_owner();
    do_reset();
    req_port = 4'b0001;
    step();
    req_port = 4'b0000; HSELM = 1'b1;
    step();
    checks++; if (addr_in_port !== 2'd0 || no_port !== 1'b0) begin errors++; $display("FAIL keep_owner: got port %0d no_port %b expected port 0 no_port 0", addr_in_port, no_port); end
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    req_port = 4'b1111; HSELM = 1'b1; HTRANSM = NONSEQ; HBURSTM = SINGLE;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (addr_in_port !== 2'(exp_seq[i])) begin errors++; $display("FAIL rr_step%0d: got %0d expected %0d", i, addr_in_port, exp_seq[i]); end
    end
  endtask

  task automatic test_fixed_burst();
    do_reset();
    req_port = 4'b0001;
    step();
    req_port = 4'b1110; HSELM = 1'b1; HBURSTM = INCR8;
    for (int b = 0; b < 8; b++) begin
      HTRANSM = (b == 0) ? NONSEQ : SEQ;
      step();
      checks++; if (arb_hold !== (b < 7) || addr_in_port !== 2'd0) begin errors++; $display("FAIL incr8_beat%0d: got hold %b port %0d expected hold %b port 0", b, arb_hold, addr_in_port, (b < 7)); end
    end
    HTRANSM = IDLE;
    step();
    checks++; if (addr_in_port !== 2'd1) begin errors++; $display("FAIL incr8_handover: got %0d expected 1", addr_in_port); end
  endtask

  task automatic test_incr_window();
    do_reset();
    req_port = 4'b1100;
    step();
    checks++; if (addr_in_port !== 2'd2) begin errors++; $display("FAIL incr_setup: got %0d expected 2", addr_in_port); end
    HSELM = 1'b1; HBURSTM = INCR;
    for (int b = 0; b < 9; b++) begin
      HTRANSM = (b == 0) ? NONSEQ : SEQ;
      step();
      if (b < 8) begin
        checks++; if (arb_hold !== (b < 7) || addr_in_port !== 2'd2) begin errors++; $display("FAIL incr_beat%0d: got hold %b port %0d expected hold %b port 2", b, arb_hold, addr_in_port, (b < 7)); end
      end else begin
        checks++; if (addr_in_port !== 2'd3) begin errors++; $display("FAIL incr_cut: got %0d expected 3", addr_in_port); end
      end
    end
    do_reset();
    req_port = 4'b1100;
    step();
    HSELM = 1'b1; HBURSTM = INCR; HMASTLOCKM = 1'b1;
    for (int b = 0; b < 20; b++) begin
      HTRANSM = (b == 0) ? NONSEQ : SEQ;
      step();
      checks++; if (arb_hold !== 1'b1 || addr_in_port !== 2'd2) begin errors++; $display("FAIL locked_beat%0d: got hold %b port %0d expected hold 1 port 2", b, arb_hold, addr_in_port); end
    end
    HMASTLOCKM = 1'b0; HTRANSM = IDLE;
    step();
    step();
    checks++; if (addr_in_port !== 2'd3) begin errors++; $display("FAIL locked_release: got %0d expected 3", addr_in_port); end
  endtask

  task automatic test_hready_stall();
    do_reset();
    HREADYM = 1'b0; req_port = 4'b0010;
    step();
    checks++; if (no_port !== 1'b1) begin errors++; $display("FAIL stall_ignore_req: got no_port %b expected 1", no_port); end
    HREADYM = 1'b1; req_port = 4'b0011;
    step();
    HSELM = 1'b1; HBURSTM = INCR4; HTRANSM = NONSEQ;
    step();
    HTRANSM = SEQ;
    step();
    HREADYM = 1'b0; req_port = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (arb_hold !== 1'b1 || addr_in_port !== 2'd0) begin errors++; $display("FAIL stall_cycle%0d: got hold %b port %0d expected hold 1 port 0", c, arb_hold, addr_in_port); end
    end
    HREADYM = 1'b1;
    step();
    checks++; if (arb_hold !== 1'b1) begin errors++; $display("FAIL stall_beat3: got hold %b expected 1", arb_hold); end
    step();
    checks++; if (arb_hold !== 1'b0 || addr_in_port !== 2'd0) begin errors++; $display("FAIL stall_beat4: got hold %b port %0d expected hold 0 port 0", arb_hold, addr_in_port); end
    HTRANSM = IDLE;
    step();
    checks++; if (addr_in_port !== 2'd1) begin errors++; $display("FAIL stall_handover: got %0d expected 1", addr_in_port); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_port = 4'b0010;
    step();
    HSELM = 1'b1; HBURSTM = WRAP16; HTRANSM = NONSEQ;
    step();
    HTRANSM = SEQ;
    step();
    step();
    checks++; if (arb_hold !== 1'b1 || addr_in_port !== 2'd1) begin errors++; $display("FAIL wrap16_pre: got hold %b port %0d expected hold 1 port 1", arb_hold, addr_in_port); end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if (no_port !== 1'b1 || addr_in_port !== 2'd0 || arb_hold !== 1'b0) begin errors++; $display("FAIL async_reset: got no_port %b port %0d hold %b expected 1 0 0", no_port, addr_in_port, arb_hold); end
    HRESETn = 1'b1;
  endtask

  task automatic test_deselect();
    do_reset();
    req_port = 4'b0011;
    step();
    HSELM = 1'b1; HBURSTM = INCR16; HTRANSM = NONSEQ;
    step();
    HTRANSM = SEQ;
    step();
    HSELM = 1'b0;
    step();
    checks++; if (arb_hold !== 1'b0 || addr_in_port !== 2'd0) begin errors++; $display("FAIL deselect_clear: got hold %b port %0d expected hold 0 port 0", arb_hold, addr_in_port); end
    step();
    checks++; if (addr_in_port !== 2'd1) begin errors++; $display("FAIL deselect_handover: got %0d expected 1", addr_in_port); end
  endtask

`ifdef ARB_PRIO_EN
  task automatic test_prio();
    int exp_seq[6] = '{3, 3, 0, 3, 3, 0};
    do_reset();
    req_port = 4'b1001; HSELM = 1'b1; HTRANSM = NONSEQ; HBURSTM = SINGLE;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (addr_in_port !== 2'(exp_seq[i])) begin errors++; $display("FAIL prio_step%0d: got %0d expected %0d", i, addr_in_port, exp_seq[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_grant();
    test_keep_owner();
    test_round_robin();
    test_fixed_burst();
    test_incr_window();
    test_hready_stall();
    test_async_reset();
    test_deselect();
`ifdef ARB_PRIO_EN
    test_prio();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
